// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decoder.
// One instruction + PC is accepted per valid/ready handshake. The decoded
// bundle (class, register indices, funct fields, immediate, illegal flag)
// is held in a single output register with backpressure and flush.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [10:0]     out_class,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_ALU_IMM  = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  // Bit positions inside the one-hot class vector.
  typedef enum logic [3:0] {
    C_LUI      = 4'd0,
    C_AUIPC    = 4'd1,
    C_JAL      = 4'd2,
    C_JALR     = 4'd3,
    C_BRANCH   = 4'd4,
    C_LOAD     = 4'd5,
    C_STORE    = 4'd6,
    C_ALU_IMM  = 4'd7,
    C_ALU_REG  = 4'd8,
    C_SYSTEM   = 4'd9,
    C_MISC_MEM = 4'd10
  } class_idx_e;

  // Immediate format chosen for the current opcode.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Output payload registers.
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [10:0]     r_class;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  // Field slices of the incoming word.
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_sign;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_sign   = in_instr[31];

  // Sign-extended immediates for every format, built directly at XLEN.
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_imm_i = {{(XLEN-11){w_sign}}, in_instr[30:20]};
  assign w_imm_s = {{(XLEN-11){w_sign}}, in_instr[30:25], in_instr[11:7]};
  assign w_imm_b = {{(XLEN-12){w_sign}}, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){w_sign}}, in_instr[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){w_sign}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // Shift-immediate encodings: the upper field shrinks by one bit on RV64
  // because shamt grows to 6 bits.
  logic w_slli_ok;
  logic w_sri_ok;

  // Legal shift-immediate upper field for the configured XLEN.
  always_comb begin
    if (XLEN == 64) begin
      w_slli_ok = (in_instr[31:26] == 6'b000000);
      w_sri_ok  = (in_instr[31:26] == 6'b000000) ||
                  (in_instr[31:26] == 6'b010000);
    end else begin
      w_slli_ok = (in_instr[31:25] == 7'b0000000);
      w_sri_ok  = (in_instr[31:25] == 7'b0000000) ||
                  (in_instr[31:25] == 7'b0100000);
    end
  end

  // ALU_REG funct7 legality; MUL/DIV only when the M extension is enabled.
  logic w_funct7_ok;
  assign w_funct7_ok = (w_funct7 == 7'b0000000) ||
                       (w_funct7 == 7'b0100000) ||
                       (ENABLE_M && (w_funct7 == 7'b0000001));

  // Decoded class, immediate format and illegal flag for in_instr.
  logic [10:0]     w_class_raw;
  imm_fmt_e        w_fmt;
  logic            w_bad;
  logic [10:0]     w_class;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;

  // Opcode classification and per-class encoding checks.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    w_class_raw = '0;
    w_fmt       = IMM_NONE;
    w_bad       = 1'b0;
    unique case (w_opcode)
      OP_LUI: begin
        w_class_raw[C_LUI] = 1'b1;
        w_fmt              = IMM_U;
      end
      OP_AUIPC: begin
        w_class_raw[C_AUIPC] = 1'b1;
        w_fmt                = IMM_U;
      end
      OP_JAL: begin
        w_class_raw[C_JAL] = 1'b1;
        w_fmt              = IMM_J;
      end
      OP_JALR: begin
        w_class_raw[C_JALR] = 1'b1;
        w_fmt               = IMM_I;
        w_bad               = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_class_raw[C_BRANCH] = 1'b1;
        w_fmt                 = IMM_B;
        w_bad                 = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OP_LOAD: begin
        w_class_raw[C_LOAD] = 1'b1;
        w_fmt               = IMM_I;
      end
      OP_STORE: begin
        w_class_raw[C_STORE] = 1'b1;
        w_fmt                = IMM_S;
      end
      OP_ALU_IMM: begin
        w_class_raw[C_ALU_IMM] = 1'b1;
        w_fmt                  = IMM_I;
        if (w_funct3 == 3'b001) begin
          w_bad = !w_slli_ok;
        end else if (w_funct3 == 3'b101) begin
          w_bad = !w_sri_ok;
        end
      end
      OP_ALU_REG: begin
        w_class_raw[C_ALU_REG] = 1'b1;
        w_fmt                  = IMM_NONE;
        w_bad                  = !w_funct7_ok;
      end
      OP_SYSTEM: begin
        w_class_raw[C_SYSTEM] = 1'b1;
        w_fmt                 = IMM_I;
      end
      OP_MISC_MEM: begin
        w_class_raw[C_MISC_MEM] = 1'b1;
        w_fmt                   = IMM_I;
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
    // Compressed / non-32-bit encodings are rejected outright.
    if (in_instr[1:0] != 2'b11) begin
      w_bad = 1'b1;
    end
  end

  // Immediate mux and suppression of class/immediate for illegal words.
  always_comb begin
    w_illegal = w_bad;
    w_class   = w_bad ? 11'b0 : w_class_raw;
    w_imm     = '0;
    if (!w_bad) begin
      unique case (w_fmt)
        IMM_I:   w_imm = w_imm_i;
        IMM_S:   w_imm = w_imm_s;
        IMM_B:   w_imm = w_imm_b;
        IMM_U:   w_imm = w_imm_u;
        IMM_J:   w_imm = w_imm_j;
        default: w_imm = '0;
      endcase
    end
  end

  // Handshake: a single register with no skid buffer, so the stage is ready
  // whenever it is empty or its content is being consumed this cycle.
  logic w_capture;
  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // Valid bit: flush wins, then capture, then consume.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload registers load only on capture and otherwise hold.
  // NOTE: the payload is reset too, because the interface promises all-zero
  // outputs after reset rather than leaving them undefined.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pc      <= '0;
      r_class   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_pc      <= in_pc;
      r_class   <= w_class;
      r_rs1     <= in_instr[19:15];
      r_rs2     <= in_instr[24:20];
      r_rd      <= in_instr[11:7];
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_imm     <= w_imm;
      r_illegal <= w_illegal;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_class   = r_class;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_funct3  = r_funct3;
  assign out_funct7  = r_funct7;
  assign out_imm     = r_imm;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. Two instances share the
// input side: u32 (XLEN=32, no M) and u64 (XLEN=64, with M).
module tb_decode_stage;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [10:0] a_class;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [10:0] b_class;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u32 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_class(a_class), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm),
    .out_illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) u64 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_class(b_class), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm),
    .out_illegal(b_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction with out_ready=1 and return #1 after the edge.
  task automatic drive_one(input logic [31:0] instr, input logic [63:0] pc);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    @(posedge aclk);
    #1;
    in_valid  = 1'b0;
  endtask

  // Decode one word and compare both instances against hand-computed values.
  task automatic vec(input string tag, input logic [31:0] instr,
                     input logic [10:0] c32, input logic [31:0] i32,
                     input logic l32, input logic [10:0] c64,
                     input logic [63:0] i64, input logic l64);
    drive_one(instr, 64'h0000_0001_0000_0100);
    check({tag, ".v32"},   {63'b0, a_out_valid}, 64'd1);
    check({tag, ".cls32"}, {53'b0, a_class},     {53'b0, c32});
    check({tag, ".imm32"}, {32'b0, a_imm},       {32'b0, i32});
    check({tag, ".ill32"}, {63'b0, a_illegal},   {63'b0, l32});
    check({tag, ".cls64"}, {53'b0, b_class},     {53'b0, c64});
    check({tag, ".imm64"}, b_imm,                i64);
    check({tag, ".ill64"}, {63'b0, b_illegal},   {63'b0, l64});
  endtask

  logic [31:0] bp_instr [3];
  int sent, recv;

  initial begin
    bp_instr[0] = 32'h0010_0093;   // addi x1,x0,1
    bp_instr[1] = 32'h0020_0113;   // addi x2,x0,2
    bp_instr[2] = 32'h0030_0193;   // addi x3,x0,3

    aresetn   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #3;
    check("rst.valid",  {63'b0, a_out_valid}, 64'd0);
    check("rst.class",  {53'b0, b_class},     64'd0);
    check("rst.imm",    b_imm,                64'd0);
    check("rst.ill",    {63'b0, a_illegal},   64'd0);
    check("rst.ready",  {63'b0, a_in_ready},  64'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // addi x1,x0,5 with field checks
    vec("addi", 32'h0050_0093, 11'h080, 32'h5, 1'b0, 11'h080, 64'h5, 1'b0);
    check("addi.rd",  {59'b0, a_rd},  64'd1);
    check("addi.rs1", {59'b0, a_rs1}, 64'd0);
    check("addi.pc32", {32'b0, a_pc}, 64'h0000_0100);
    check("addi.pc64", b_pc,          64'h0000_0001_0000_0100);
    vec("lui", 32'h1234_52B7, 11'h001, 32'h1234_5000, 1'b0,
        11'h001, 64'h0000_0000_1234_5000, 1'b0);
    check("lui.rd", {59'b0, b_rd}, 64'd5);
    vec("lui_neg", 32'hFFFF_F2B7, 11'h001, 32'hFFFF_F000, 1'b0,
        11'h001, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
    vec("beq", 32'hFE00_0EE3, 11'h010, 32'hFFFF_FFFC, 1'b0,
        11'h010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    vec("jal", 32'h0000_006F, 11'h004, 32'h0, 1'b0, 11'h004, 64'h0, 1'b0);
    vec("zero", 32'h0000_0000, 11'h000, 32'h0, 1'b1, 11'h000, 64'h0, 1'b1);
    vec("mul", 32'h0220_8033, 11'h000, 32'h0, 1'b1, 11'h100, 64'h0, 1'b0);
    check("mul.f7",  {57'b0, b_f7},  64'd1);
    check("mul.rs2", {59'b0, b_rs2}, 64'd2);
    check("mul.rs1", {59'b0, a_rs1}, 64'd1);
    vec("slli32", 32'h0200_9093, 11'h000, 32'h0, 1'b1, 11'h080, 64'h20, 1'b0);
    vec("srai", 32'h4030_D093, 11'h080, 32'h403, 1'b0, 11'h080, 64'h403, 1'b0);
    vec("jalr_f3", 32'h0000_9067, 11'h000, 32'h0, 1'b1, 11'h000, 64'h0, 1'b1);
    vec("br_f3", 32'h0000_2063, 11'h000, 32'h0, 1'b1, 11'h000, 64'h0, 1'b1);
    vec("badop", 32'h0000_007F, 11'h000, 32'h0, 1'b1, 11'h000, 64'h0, 1'b1);
    vec("sw", 32'hFE20_AE23, 11'h040, 32'hFFFF_FFFC, 1'b0,
        11'h040, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check("sw.f3", {61'b0, a_f3}, 64'd2);
    vec("lw", 32'hFFF1_2083, 11'h020, 32'hFFFF_FFFF, 1'b0,
        11'h020, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    vec("auipc", 32'h0000_1097, 11'h002, 32'h1000, 1'b0, 11'h002, 64'h1000, 1'b0);
    vec("sub", 32'h4000_0033, 11'h100, 32'h0, 1'b0, 11'h100, 64'h0, 1'b0);
    vec("fence", 32'h0FF0_000F, 11'h400, 32'hFF, 1'b0, 11'h400, 64'hFF, 1'b0);
    vec("ecall", 32'h0000_0073, 11'h200, 32'h0, 1'b0, 11'h200, 64'h0, 1'b0);

    // Drain so the backpressure run starts empty.
    out_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("drain.valid", {63'b0, a_out_valid}, 64'd0);

    // Backpressure: first bundle stalls for 4 cycles, then all three drain
    // in order, one per cycle.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 3; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 3);
      in_instr  = bp_instr[(sent < 3) ? sent : 2];
      #1;
      if (cyc >= 1 && cyc <= 4) begin
        check("bp.stall_ready", {63'b0, a_in_ready},  64'd0);
        check("bp.stall_valid", {63'b0, b_out_valid}, 64'd1);
        check("bp.stall_rd",    {59'b0, a_rd},        64'd1);
      end
      if (a_out_valid && out_ready) begin
        check("bp.order32", {59'b0, a_rd}, 64'(recv + 1));
        check("bp.order64", {59'b0, b_rd}, 64'(recv + 1));
        recv++;
      end
      if (in_valid && a_in_ready) begin
        sent++;
      end
      @(posedge aclk);
      #1;
    end
    in_valid = 1'b0;
    check("bp.recv", 64'(recv), 64'd3);
    check("bp.empty", {63'b0, a_out_valid}, 64'd0);

    // Flush with a held bundle and a concurrent input beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0093;
    @(posedge aclk);
    #1;
    check("fl.held", {63'b0, a_out_valid}, 64'd1);
    flush    = 1'b1;
    in_instr = 32'h0030_0193;
    @(posedge aclk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl.valid", {63'b0, a_out_valid}, 64'd0);
    check("fl.keep_rd", {59'b0, b_rd}, 64'd1);
    check("fl.keep_imm", {32'b0, a_imm}, 64'd5);
    @(posedge aclk);
    #1;
    check("fl.nocap", {63'b0, b_out_valid}, 64'd0);

    // Asynchronous reset mid-stream with a held bundle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0220_8033;
    in_pc     = 64'h44;
    @(posedge aclk);
    #1;
    in_valid = 1'b0;
    check("ar.pre_ill", {63'b0, a_illegal}, 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar.valid", {63'b0, a_out_valid}, 64'd0);
    check("ar.ill",   {63'b0, a_illegal},   64'd0);
    check("ar.class", {53'b0, b_class},     64'd0);
    check("ar.pc",    b_pc,                 64'd0);
    check("ar.rs2",   {59'b0, b_rs2},       64'd0);
    check("ar.f7",    {57'b0, b_f7},        64'd0);
    check("ar.ready", {63'b0, b_in_ready},  64'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("ar.after", {63'b0, b_out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
